usb_out_ep_buffer: RTL and testbench

- Single-packet USB full-speed OUT endpoint buffer.
- Sits between the USB protocol engine's receive path and one OUT-endpoint consumer, e.g. the SPI bridge endpoint.
- Stores one DATA payload, checks the data toggle, chooses the ACK/NAK/STALL handshake, and presents bytes through the standard `out_ep_*` request/grant/get interface.

---
 rtl/usb_ep_pkg.sv | 21 ++
 rtl/usb_ep_ram.sv | 36 +++
 rtl/usb_out_ep_buffer.sv | 185 ++++++++++++++++++
 tb/tb_usb_out_ep_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ep_pkg.sv
// Shared definitions for the USB endpoint buffers: buffer state encoding,
// default packet size and the handshake codes used by both IN and OUT sides.
package usb_ep_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_RX      = 2'd1,
        ST_FULL    = 2'd2,
        ST_DISCARD = 2'd3
    } ep_state_e;

    localparam int DEFAULT_MAX_PKT_SIZE = 64;

    typedef enum logic [1:0] {
        HS_NONE  = 2'd0,
        HS_ACK   = 2'd1,
        HS_NAK   = 2'd2,
        HS_STALL = 2'd3
    } hs_e;

endpackage

// File: rtl/usb_ep_ram.sv
// Byte-wide simple dual-port RAM: one write port, one registered read port.
// The read register resets to zero and holds its value when not read.
module usb_ep_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            rd_data_q <= 8'h00;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/usb_out_ep_buffer.sv
// Single-packet full-speed OUT endpoint buffer: stores one DATA payload,
// checks the data toggle, picks the handshake and serves bytes to a consumer.
module usb_out_ep_buffer
    import usb_ep_pkg::*;
#(
    parameter int MAX_PKT_SIZE = DEFAULT_MAX_PKT_SIZE
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       rx_pkt_start,
    input  logic       rx_pkt_setup,
    input  logic       rx_pkt_data1,
    input  logic       rx_data_put,
    input  logic [7:0] rx_data,
    input  logic       rx_pkt_end,
    input  logic       rx_pkt_valid,
    output logic       rx_hs_ack,
    output logic       rx_hs_nak,
    output logic       rx_hs_stall,
    input  logic       out_ep_req,
    output logic       out_ep_grant,
    output logic       out_ep_data_avail,
    output logic       out_ep_setup,
    input  logic       out_ep_data_get,
    output logic [7:0] out_ep_data,
    input  logic       out_ep_stall,
    output logic       out_ep_acked
);

    localparam int AW = $clog2(MAX_PKT_SIZE);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] MAX_CNT = PW'(MAX_PKT_SIZE);

    ep_state_e     state_q, state_d;
    hs_e           hs_q, hs_d;
    logic          toggle_q, toggle_d;
    logic          setup_q, setup_d;
    logic          data1_q, data1_d;
    logic          ovf_q, ovf_d;
    logic          grant_q, grant_d;
    logic          acked_q, acked_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] len_q, len_d;
    logic          in_buf, avail, wr_en, rd_en, revoke;

    assign in_buf = (state_q == ST_FULL) || (state_q == ST_DISCARD);
    assign avail  = in_buf && (rptr_q < len_q);
    assign rd_en  = out_ep_data_get && grant_q && avail;

    always_comb begin
        state_d  = state_q;
        hs_d     = HS_NONE;
        toggle_d = toggle_q;
        setup_d  = setup_q;
        data1_d  = data1_q;
        ovf_d    = ovf_q;
        acked_d  = 1'b0;
        wptr_d   = wptr_q;
        rptr_d   = rd_en ? rptr_q + 1'b1 : rptr_q;
        len_d    = len_q;
        wr_en    = 1'b0;
        revoke   = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (rx_pkt_start) begin
                    setup_d = rx_pkt_setup;
                    data1_d = rx_pkt_data1;
                    wptr_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_RX;
                end
            end
            ST_RX: begin
                if (rx_data_put) begin
                    if (wptr_q == MAX_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                    end
                end
                if (rx_pkt_end) begin
                    state_d = ST_EMPTY;
                    if (!rx_pkt_valid || ovf_q) begin
                        hs_d = HS_NONE;
                    end else if (out_ep_stall && !setup_q) begin
                        hs_d = HS_STALL;
                    end else if ((data1_q != toggle_q) && !setup_q) begin
                        hs_d = HS_ACK;
                    end else begin
                        hs_d     = HS_ACK;
                        acked_d  = 1'b1;
                        toggle_d = setup_q ? 1'b1 : !data1_q;
                        len_d    = wptr_q;
                        rptr_d   = '0;
                        state_d  = (wptr_q == '0) ? ST_EMPTY : ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                // A SETUP always wins over an unread OUT payload; a plain OUT must wait.
                if (rx_pkt_start && rx_pkt_setup) begin
                    setup_d = 1'b1;
                    data1_d = rx_pkt_data1;
                    wptr_d  = '0;
                    ovf_d   = 1'b0;
                    revoke  = 1'b1;
                    state_d = ST_RX;
                end else if (rx_pkt_start) begin
                    state_d = ST_DISCARD;
                end else if (rptr_d >= len_q) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_DISCARD: begin
                if (rx_pkt_end) begin
                    if (!rx_pkt_valid) begin
                        hs_d = HS_NONE;
                    end else if (out_ep_stall) begin
                        hs_d = HS_STALL;
                    end else begin
                        hs_d = HS_NAK;
                    end
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        grant_d = out_ep_req && in_buf && (grant_q || avail) && !revoke;
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q  <= ST_EMPTY;
            hs_q     <= HS_NONE;
            toggle_q <= 1'b0;
            setup_q  <= 1'b0;
            data1_q  <= 1'b0;
            ovf_q    <= 1'b0;
            grant_q  <= 1'b0;
            acked_q  <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            hs_q     <= hs_d;
            toggle_q <= toggle_d;
            setup_q  <= setup_d;
            data1_q  <= data1_d;
            ovf_q    <= ovf_d;
            grant_q  <= grant_d;
            acked_q  <= acked_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            len_q    <= len_d;
        end
    end

    usb_ep_ram #(
        .DEPTH (MAX_PKT_SIZE),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset_b (reset_b),
        .wr_en   (wr_en),
        .wr_addr (wptr_q[AW-1:0]),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_addr (rptr_q[AW-1:0]),
        .rd_data (out_ep_data)
    );

    assign rx_hs_ack         = (hs_q == HS_ACK);
    assign rx_hs_nak         = (hs_q == HS_NAK);
    assign rx_hs_stall       = (hs_q == HS_STALL);
    assign out_ep_acked      = acked_q;
    assign out_ep_grant      = grant_q;
    assign out_ep_data_avail = avail;
    assign out_ep_setup      = in_buf && setup_q;

endmodule

// File: tb/tb_usb_out_ep_buffer.sv
// Directed bench for the OUT endpoint buffer: each task drives one scenario
// and compares outputs against hand-computed values.
module tb_usb_out_ep_buffer;

    logic       clk;
    logic       reset_b;
    logic       rx_pkt_start, rx_pkt_setup, rx_pkt_data1;
    logic       rx_data_put;
    logic [7:0] rx_data;
    logic       rx_pkt_end, rx_pkt_valid;
    logic       rx_hs_ack, rx_hs_nak, rx_hs_stall;
    logic       out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup;
    logic       out_ep_data_get;
    logic [7:0] out_ep_data;
    logic       out_ep_stall;
    logic       out_ep_acked;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pkt_bytes [0:127];
    logic       hs_ack, hs_nak, hs_stall, hs_acked;

    usb_out_ep_buffer #(.MAX_PKT_SIZE(64)) dut (
        .clk               (clk),
        .reset_b           (reset_b),
        .rx_pkt_start      (rx_pkt_start),
        .rx_pkt_setup      (rx_pkt_setup),
        .rx_pkt_data1      (rx_pkt_data1),
        .rx_data_put       (rx_data_put),
        .rx_data           (rx_data),
        .rx_pkt_end        (rx_pkt_end),
        .rx_pkt_valid      (rx_pkt_valid),
        .rx_hs_ack         (rx_hs_ack),
        .rx_hs_nak         (rx_hs_nak),
        .rx_hs_stall       (rx_hs_stall),
        .out_ep_req        (out_ep_req),
        .out_ep_grant      (out_ep_grant),
        .out_ep_data_avail (out_ep_data_avail),
        .out_ep_setup      (out_ep_setup),
        .out_ep_data_get   (out_ep_data_get),
        .out_ep_data       (out_ep_data),
        .out_ep_stall      (out_ep_stall),
        .out_ep_acked      (out_ep_acked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one packet from pkt_bytes and captures the handshake seen one cycle after end.
    task automatic send_pkt(input logic setup, input logic d1, input int n, input logic valid);
        rx_pkt_start = 1'b1; rx_pkt_setup = setup; rx_pkt_data1 = d1;
        tick;
        rx_pkt_start = 1'b0; rx_pkt_setup = 1'b0; rx_pkt_data1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_data_put = 1'b1; rx_data = pkt_bytes[i];
            tick;
        end
        rx_data_put = 1'b0; rx_data = 8'h00;
        rx_pkt_end = 1'b1; rx_pkt_valid = valid;
        tick;
        rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
        hs_ack = rx_hs_ack; hs_nak = rx_hs_nak; hs_stall = rx_hs_stall; hs_acked = out_ep_acked;
    endtask

    task automatic test_reset;
        reset_b = 1'b0;
        tick; tick;
        n_cmp++; if (rx_hs_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ack: got %b want 0", rx_hs_ack); end
        n_cmp++; if (out_ep_grant !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_grant: got %b want 0", out_ep_grant); end
        n_cmp++; if (out_ep_data_avail !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_avail: got %b want 0", out_ep_data_avail); end
        n_cmp++; if (out_ep_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_data: got %h want 00", out_ep_data); end
        reset_b = 1'b1;
        tick;
    endtask

    task automatic test_basic_read;
        pkt_bytes[0] = 8'h11; pkt_bytes[1] = 8'h22; pkt_bytes[2] = 8'h33;
        send_pkt(1'b0, 1'b0, 3, 1'b1);
        n_cmp++; if (hs_ack !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_ack: got %b want 1", hs_ack); end
        n_cmp++; if (hs_acked !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_acked: got %b want 1", hs_acked); end
        n_cmp++; if (hs_nak !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_nak: got %b want 0", hs_nak); end
        n_cmp++; if (out_ep_data_avail !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_avail: got %b want 1", out_ep_data_avail); end
        out_ep_req = 1'b1;
        tick;
        n_cmp++; if (rx_hs_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_ack_pulse: got %b want 0", rx_hs_ack); end
        n_cmp++; if (out_ep_grant !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_grant: got %b want 1", out_ep_grant); end
        out_ep_data_get = 1'b1;
        tick;
        n_cmp++; if (out_ep_data !== 8'h11) begin n_bad++; $display("[TB] FAIL basic_byte0: got %h want 11", out_ep_data); end
        tick;
        n_cmp++; if (out_ep_data !== 8'h22) begin n_bad++; $display("[TB] FAIL basic_byte1: got %h want 22", out_ep_data); end
        tick;
        n_cmp++; if (out_ep_data !== 8'h33) begin n_bad++; $display("[TB] FAIL basic_byte2: got %h want 33", out_ep_data); end
        n_cmp++; if (out_ep_data_avail !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_avail_drop: got %b want 0", out_ep_data_avail); end
        out_ep_data_get = 1'b0;
        tick;
        n_cmp++; if (out_ep_grant !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_grant_drop: got %b want 0", out_ep_grant); end
        n_cmp++; if (out_ep_data !== 8'h33) begin n_bad++; $display("[TB] FAIL basic_data_hold: got %h want 33", out_ep_data); end
        out_ep_req = 1'b0;
        tick;
    endtask

    task automatic test_duplicate;
        pkt_bytes[0] = 8'h99;
        send_pkt(1'b0, 1'b0, 1, 1'b1);
        n_cmp++; if (hs_ack !== 1'b1) begin n_bad++; $display("[TB] FAIL dup_ack: got %b want 1", hs_ack); end
        n_cmp++; if (hs_acked !== 1'b0) begin n_bad++; $display("[TB] FAIL dup_acked: got %b want 0", hs_acked); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_ep_data_avail !== 1'b0) begin n_bad++; $display("[TB] FAIL dup_avail%0d: got %b want 0", i, out_ep_data_avail); end
            tick;
        end
    endtask

    task automatic test_nak_while_full;
        pkt_bytes[0] = 8'hA1; pkt_bytes[1] = 8'hA2;
        send_pkt(1'b0, 1'b1, 2, 1'b1);
        n_cmp++; if (hs_acked !== 1'b1) begin n_bad++; $display("[TB] FAIL full_acked: got %b want 1", hs_acked); end
        pkt_bytes[0] = 8'hB1;
        send_pkt(1'b0, 1'b0, 1, 1'b1);
        n_cmp++; if (hs_nak !== 1'b1) begin n_bad++; $display("[TB] FAIL full_nak: got %b want 1", hs_nak); end
        n_cmp++; if (hs_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL full_no_ack: got %b want 0", hs_ack); end
        n_cmp++; if (out_ep_data_avail !== 1'b1) begin n_bad++; $display("[TB] FAIL full_avail: got %b want 1", out_ep_data_avail); end
        out_ep_req = 1'b1;
        tick;
        out_ep_data_get = 1'b1;
        tick;
        n_cmp++; if (out_ep_data !== 8'hA1) begin n_bad++; $display("[TB] FAIL full_byte0: got %h want a1", out_ep_data); end
        tick;
        n_cmp++; if (out_ep_data !== 8'hA2) begin n_bad++; $display("[TB] FAIL full_byte1: got %h want a2", out_ep_data); end
        out_ep_data_get = 1'b0;
        tick;
        out_ep_req = 1'b0;
        tick;
        n_cmp++; if (out_ep_data_avail !== 1'b0) begin n_bad++; $display("[TB] FAIL full_drained: got %b want 0", out_ep_data_avail); end
    endtask

    task automatic test_setup_stall;
        out_ep_stall = 1'b1;
        for (int i = 0; i < 8; i++) pkt_bytes[i] = 8'h40 + 8'(i);
        send_pkt(1'b1, 1'b0, 8, 1'b1);
        n_cmp++; if (hs_ack !== 1'b1) begin n_bad++; $display("[TB] FAIL setup_ack: got %b want 1", hs_ack); end
        n_cmp++; if (hs_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL setup_no_stall: got %b want 0", hs_stall); end
        n_cmp++; if (out_ep_setup !== 1'b1) begin n_bad++; $display("[TB] FAIL setup_flag: got %b want 1", out_ep_setup); end
        pkt_bytes[0] = 8'hEE;
        send_pkt(1'b0, 1'b1, 1, 1'b1);
        n_cmp++; if (hs_stall !== 1'b1) begin n_bad++; $display("[TB] FAIL setup_then_stall: got %b want 1", hs_stall); end
        n_cmp++; if (hs_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL setup_then_no_ack: got %b want 0", hs_ack); end
        out_ep_req = 1'b1;
        tick;
        out_ep_data_get = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            n_cmp++; if (out_ep_data !== 8'h40 + 8'(i)) begin n_bad++; $display("[TB] FAIL setup_byte%0d: got %h want %h", i, out_ep_data, 8'h40 + 8'(i)); end
        end
        out_ep_data_get = 1'b0;
        tick;
        out_ep_req = 1'b0;
        out_ep_stall = 1'b0;
        tick;
        n_cmp++; if (out_ep_data_avail !== 1'b0) begin n_bad++; $display("[TB] FAIL setup_drained: got %b want 0", out_ep_data_avail); end
    endtask

    task automatic test_overflow_invalid_zlp;
        for (int i = 0; i < 65; i++) pkt_bytes[i] = 8'(i);
        send_pkt(1'b0, 1'b1, 65, 1'b1);
        n_cmp++; if ({hs_ack, hs_nak, hs_stall, hs_acked} !== 4'b0000) begin n_bad++; $display("[TB] FAIL ovf_hs: got %b want 0000", {hs_ack, hs_nak, hs_stall, hs_acked}); end
        n_cmp++; if (out_ep_data_avail !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_avail: got %b want 0", out_ep_data_avail); end
        send_pkt(1'b0, 1'b1, 3, 1'b0);
        n_cmp++; if ({hs_ack, hs_nak, hs_stall, hs_acked} !== 4'b0000) begin n_bad++; $display("[TB] FAIL invalid_hs: got %b want 0000", {hs_ack, hs_nak, hs_stall, hs_acked}); end
        send_pkt(1'b0, 1'b1, 0, 1'b1);
        n_cmp++; if (hs_ack !== 1'b1) begin n_bad++; $display("[TB] FAIL zlp_ack: got %b want 1", hs_ack); end
        n_cmp++; if (hs_acked !== 1'b1) begin n_bad++; $display("[TB] FAIL zlp_acked: got %b want 1", hs_acked); end
        n_cmp++; if (out_ep_data_avail !== 1'b0) begin n_bad++; $display("[TB] FAIL zlp_avail: got %b want 0", out_ep_data_avail); end
        tick;
    endtask

    task automatic test_reset_mid_packet;
        rx_pkt_start = 1'b1; rx_pkt_data1 = 1'b0;
        tick;
        rx_pkt_start = 1'b0;
        rx_data_put = 1'b1; rx_data = 8'hC1;
        tick;
        rx_data = 8'hC2;
        tick;
        reset_b = 1'b0;
        tick;
        n_cmp++; if ({rx_hs_ack, rx_hs_nak, rx_hs_stall, out_ep_acked, out_ep_grant, out_ep_data_avail, out_ep_setup} !== 7'b0)
            begin n_bad++; $display("[TB] FAIL midreset_flags: got %b want 0000000", {rx_hs_ack, rx_hs_nak, rx_hs_stall, out_ep_acked, out_ep_grant, out_ep_data_avail, out_ep_setup}); end
        n_cmp++; if (out_ep_data !== 8'h00) begin n_bad++; $display("[TB] FAIL midreset_data: got %h want 00", out_ep_data); end
        reset_b = 1'b1;
        rx_data = 8'hC3;
        tick;
        rx_data = 8'hC4;
        tick;
        rx_data_put = 1'b0;
        rx_pkt_end = 1'b1; rx_pkt_valid = 1'b1;
        tick;
        rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
        n_cmp++; if (rx_hs_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_lost: got %b want 0", rx_hs_ack); end
        pkt_bytes[0] = 8'h5A;
        send_pkt(1'b0, 1'b0, 1, 1'b1);
        n_cmp++; if (hs_acked !== 1'b1) begin n_bad++; $display("[TB] FAIL postreset_acked: got %b want 1", hs_acked); end
        out_ep_req = 1'b1;
        tick;
        out_ep_data_get = 1'b1;
        tick;
        out_ep_data_get = 1'b0;
        n_cmp++; if (out_ep_data !== 8'h5A) begin n_bad++; $display("[TB] FAIL postreset_byte: got %h want 5a", out_ep_data); end
        out_ep_req = 1'b0;
        tick; tick;
    endtask

    initial begin
        reset_b = 1'b0;
        rx_pkt_start = 1'b0; rx_pkt_setup = 1'b0; rx_pkt_data1 = 1'b0;
        rx_data_put = 1'b0; rx_data = 8'h00;
        rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
        out_ep_req = 1'b0; out_ep_data_get = 1'b0; out_ep_stall = 1'b0;
        test_reset;
        test_basic_read;
        test_duplicate;
        test_nak_while_full;
        test_setup_stall;
        test_overflow_invalid_zlp;
        test_reset_mid_packet;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
